// File: rtl/arb_mux_4_pkg.sv
// arb_mux_4_pkg: shared constants and types for the 4-channel arbitrated mux.
//   N_CH     : number of input channels
//   ch_idx_t : channel index type
package arb_mux_4_pkg;
    localparam int N_CH = 4;
    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/mux_4_1.sv
// mux_4_1: plain combinational 4:1 multiplexer.
//   d0_i..d3_i : data inputs (W bits)
//   sel_i      : select index
//   y_o        : selected data
module mux_4_1 #(
    parameter int W = 4
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  logic [1:0]   sel_i,
    output logic [W-1:0] y_o
);
    always_comb
        y_o = sel_i[1] ? (sel_i[0] ? d3_i : d2_i) : (sel_i[0] ? d1_i : d0_i);
endmodule

// File: rtl/rr_grant_4.sv
// rr_grant_4: combinational grant picking the first requester at or after ptr.
//   in_valid : per-channel requests
//   ptr      : highest-priority channel this cycle
//   grant    : one-hot grant (zero when nothing requests)
//   idx      : granted channel index
//   any      : at least one request present
module rr_grant_4
    import arb_mux_4_pkg::*;
(
    input  logic [N_CH-1:0] in_valid,
    input  ch_idx_t         ptr,
    output logic [N_CH-1:0] grant,
    output ch_idx_t         idx,
    output logic            any
);
    logic [N_CH-1:0] rot;
    ch_idx_t         off;
    always_comb begin
        // rot[k] is the request of channel ptr+k, so the scan always starts at rot[0]
        for (int k = 0; k < N_CH; k++)
            rot[k] = in_valid[ch_idx_t'(int'(ptr) + k)];
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        idx = off + ptr;
        any = |in_valid;
        grant = '0;
        grant[idx] = any;
    end
endmodule

// File: rtl/arb_mux_4.sv
// arb_mux_4: 4-channel valid/ready arbiter feeding one registered output word.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid/in_ready : per-channel handshake
//   d0..d3            : channel data (W bits)
//   out_valid/out_ready, y, sel : registered output word and its source channel
// Macro ARB_MUX_4_RR_EN: defined -> round-robin; undefined -> fixed priority (ch0 highest).
module arb_mux_4
    import arb_mux_4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] in_valid,
    output logic [N_CH-1:0] in_ready,
    input  logic [W-1:0]    d0,
    input  logic [W-1:0]    d1,
    input  logic [W-1:0]    d2,
    input  logic [W-1:0]    d3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic [1:0]      sel
);
    logic            load_en;
    logic            ld;
    logic            any;
    logic [N_CH-1:0] grant;
    ch_idx_t         gidx;
    ch_idx_t         ptr;
    logic [W-1:0]    d_sel;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    y_q, y_d;
    ch_idx_t         sel_q, sel_d;
`ifdef ARB_MUX_4_RR_EN
    ch_idx_t         ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif
    rr_grant_4 u_grant (
        .in_valid (in_valid),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (gidx),
        .any      (any)
    );
    mux_4_1 #(.W(W)) u_mux (
        .d0_i  (d0),
        .d1_i  (d1),
        .d2_i  (d2),
        .d3_i  (d3),
        .sel_i (gidx),
        .y_o   (d_sel)
    );
    always_comb begin
        load_en = !out_valid_q || out_ready;
        // rst_n gating keeps in_ready low through reset so no channel thinks it was taken
        ld = rst_n && load_en && any;
        in_ready = (rst_n && load_en) ? grant : '0;
        out_valid_d = ld || (out_valid_q && !out_ready);
        y_d = ld ? d_sel : y_q;
        sel_d = ld ? gidx : sel_q;
`ifdef ARB_MUX_4_RR_EN
        ptr_d = ld ? gidx + 2'd1 : ptr_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q <= '0;
            sel_q <= '0;
`ifdef ARB_MUX_4_RR_EN
            ptr_q <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            y_q <= y_d;
            sel_q <= sel_d;
`ifdef ARB_MUX_4_RR_EN
            ptr_q <= ptr_d;
`endif
        end
    end
    assign out_valid = out_valid_q;
    assign y = y_q;
    assign sel = sel_q;
endmodule

// File: tb/tb_arb_mux_4.sv
// tb_arb_mux_4: scoreboard bench for arb_mux_4 (directed vectors).
module tb_arb_mux_4;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [1:0]   sel;
    logic [5:0]   exp_q[$];
    int           checks = 0;
    int           errors = 0;

    arb_mux_4 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // Monitor: every output transfer must match the oldest expected {sel, y}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_word: got sel=%0d y=%h, expected no word", sel, y);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({sel, y} !== e) begin
                    errors++;
                    $display("FAIL out_word: got sel=%0d y=%h, expected sel=%0d y=%h",
                             sel, y, e[5:4], e[3:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, check the combinational in_ready, then advance.
    task automatic cyc(input logic [3:0] v, input logic r, input logic [3:0] rdy);
        in_valid = v;
        out_ready = r;
        #1;
        chk("in_ready", {4'h0, in_ready}, {4'h0, rdy});
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] v);
        exp_q.push_back({s, v});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        @(posedge clk);
        #1;
        cyc(4'b1111, 1'b1, 4'b0000);
        cyc(4'b1111, 1'b1, 4'b0000);
        chk("rst_out_valid", {7'h0, out_valid}, 8'h00);
        chk("rst_y", {4'h0, y}, 8'h00);
        chk("rst_sel", {6'h0, sel}, 8'h00);
        rst_n = 1'b1;
`ifdef ARB_MUX_4_RR_EN
        for (int i = 0; i < 8; i++) begin
            push(2'(i % 4), 4'(i % 4 + 1));
            cyc(4'b1111, 1'b1, 4'b0001 << (i % 4));
        end
        push(2'd2, 4'h3);
        cyc(4'b0100, 1'b1, 4'b0100);
        push(2'd0, 4'h1);
        cyc(4'b0101, 1'b1, 4'b0001);
        push(2'd2, 4'h3);
        cyc(4'b0101, 1'b1, 4'b0100);
        push(2'd0, 4'h1);
        cyc(4'b0101, 1'b1, 4'b0001);
`else
        for (int i = 0; i < 4; i++) begin
            push(2'd0, 4'h1);
            cyc(4'b1111, 1'b1, 4'b0001);
        end
        for (int i = 0; i < 3; i++) begin
            push(2'd1, 4'h2);
            cyc(4'b1010, 1'b1, 4'b0010);
        end
        push(2'd0, 4'h1);
        cyc(4'b0101, 1'b1, 4'b0001);
`endif
        cyc(4'b0000, 1'b1, 4'b0000);
        chk("drain_out_valid", {7'h0, out_valid}, 8'h00);
        d1 = 4'hA;
        push(2'd1, 4'hA);
        cyc(4'b0010, 1'b1, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 1'b0, 4'b0000);
            chk("bp_out_valid", {7'h0, out_valid}, 8'h01);
            chk("bp_y", {4'h0, y}, 8'h0A);
            chk("bp_sel", {6'h0, sel}, 8'h01);
        end
        push(2'd2, 4'h3);
        cyc(4'b0100, 1'b1, 4'b0100);
        chk("release_sel", {6'h0, sel}, 8'h02);
        chk("release_y", {4'h0, y}, 8'h03);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0010, 1'b1, 4'b0010);
        cyc(4'b0000, 1'b0, 4'b0000);
        chk("stall_out_valid", {7'h0, out_valid}, 8'h01);
        rst_n = 1'b0;
        cyc(4'b1111, 1'b0, 4'b0000);
        exp_q.delete();
        chk("midrst_out_valid", {7'h0, out_valid}, 8'h00);
        rst_n = 1'b1;
        push(2'd0, 4'h1);
        cyc(4'b1111, 1'b1, 4'b0001);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/arb_mux_4.md
ARB_MUX_4 -- requirements
Module: arb_mux_4

Interface
REQ-001 Parameter: W, default 4, data width of every channel and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  4  per-channel request; bit i belongs to channel i.
REQ-005 in_ready  output  4  per-channel accept; bit i high only in the cycle channel i's data is taken.
REQ-006 d0, d1, d2, d3  input  W each  channel 0..3 data.
REQ-007 out_valid  output  1  output register holds a valid word.
REQ-008 out_ready  input  1  downstream accepts the output word.
REQ-009 y  output  W  registered selected data.
REQ-010 sel  output  2  registered index of the channel whose data is in y.

Function
REQ-011 Transfer on an input channel i SHALL occur when in_valid[i] && in_ready[i]; on the output, when out_valid && out_ready.
REQ-012 load_en SHALL be (!out_valid || out_ready); the output register loads only when load_en is high and at least one in_valid bit is high.
REQ-013 At most one in_ready bit SHALL be high per cycle; in_ready[i] = grant[i] && load_en; in_ready SHALL be 0 when no in_valid bit is high.
REQ-014 grant SHALL be combinational from in_valid and the priority pointer ptr (2 bits): the first requesting channel found scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-015 On a load, y <= d[granted], sel <= granted index, out_valid <= 1, and ptr <= granted+1 modulo 4 (3 wraps to 0).
REQ-016 With load_en high and no request, out_valid <= 0 (if out_ready consumed the word) and y, sel, ptr SHALL hold.
REQ-017 With out_valid high and out_ready low, y, sel, out_valid, ptr SHALL hold and in_ready SHALL be 0 (backpressure).
REQ-018 Latency: input transfer in cycle N -> word visible on y/sel with out_valid in cycle N+1; sustained throughput one word per cycle when out_ready is held high.
REQ-019 Simultaneous output drain and input load in the same cycle SHALL be permitted (no bubble).
REQ-020 y and sel SHALL not depend combinationally on any input; in_ready depends combinationally on in_valid, out_valid, out_ready.
REQ-021 A channel deasserting in_valid without a transfer SHALL be legal; grant is re-evaluated every cycle.

Reset
REQ-022 While rst_n is low at a rising edge: out_valid <= 0, y <= 0, sel <= 0, ptr <= 0.
REQ-023 in_ready SHALL be 0 in every cycle rst_n is low; a word held mid-backpressure SHALL be discarded by reset.

Configuration
REQ-024 Macro ARB_MUX_4_RR_EN defined: round-robin per REQ-014/REQ-015.
REQ-025 Macro ARB_MUX_4_RR_EN undefined: fixed priority, channel 0 highest, channel 3 lowest; ptr SHALL not exist (or be held at 0); all other requirements unchanged.

Structure
REQ-026 Package arb_mux_4_pkg SHALL hold N_CH = 4 and typedef ch_idx_t (logic [1:0]).
REQ-027 The grant logic SHALL be a sub-module rr_grant_4 (inputs in_valid, ptr; outputs one-hot grant, index, any); the 4:1 data selection SHALL reuse the team's mux_4_1 with sel = granted index.

Verification
REQ-028 Reset: rst_n low 2 cycles with all in_valid = 4'b1111 -> out_valid 0, y 0, sel 0, in_ready 4'b0000.
REQ-029 Round-robin (RR_EN defined): in_valid 4'b1111, d0..d3 = 1,2,3,4, out_ready 1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3, y 1,2,3,4,1,2,3,4, one in_ready bit per cycle.
REQ-030 Wrap/skip: ptr = 3, in_valid 4'b0101 -> channel 0 granted, next grant channel 2, then channel 0.
REQ-031 Backpressure: load word d1 = 4'hA, hold out_ready 0 for 3 cycles while d2 requests -> y stays 4'hA, sel 1, in_ready 0; release -> next cycle y = d2, sel 2.
REQ-032 Fixed priority (RR_EN undefined): in_valid 4'b1010 held 3 cycles with out_ready 1 -> sel 1,1,1; channel 3 starves.
REQ-033 Mid-operation reset: out_valid 1 with out_ready 0, assert rst_n low 1 cycle -> out_valid 0, ptr 0; next grant with in_valid 4'b1111 is channel 0.
